// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - calculator sequencer owning the single 8-bit ripple-carry adder (ADD/SUB/MUL)

module rca (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co,
    output logic       ovr
);
    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co  = c;
        ovr = (x[7] == y[7]) && (s[7] != x[7]);
    end
endmodule

module calc_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               cout,
    output logic               ovr,
    output logic               zero,
    output logic               err,
    output logic               busy
);
    if (WIDTH != 8) begin : g_bad_width
        $error("calc_seq: WIDTH must be 8 to match rca");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t             state, state_nx;
    logic               sub_r;
    logic [WIDTH-1:0]   a_r, b_r, hi, lo;
    logic [2:0]         cnt;
    logic [WIDTH-1:0]   add_x, add_y, sum;
    logic               add_c, add_co, add_ovr;
    logic               accept, is_rsv;
    logic [2*WIDTH-1:0] mul_next;

    assign in_ready  = rst_n && (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign is_rsv    = (op == 2'b11) || (op == 2'b10 && MUL_EN == 0);

    // The one adder is shared: operands in EXEC, partial product in MUL.
    always_comb begin
        add_x = a_r;
        add_y = b_r ^ {WIDTH{sub_r}};
        add_c = sub_r;
        if (state == S_MUL) begin
            add_x = hi;
            add_y = lo[0] ? a_r : '0;
            add_c = 1'b0;
        end
    end

    rca u_rca (
        .x   (add_x),
        .y   (add_y),
        .ci  (add_c),
        .s   (sum),
        .co  (add_co),
        .ovr (add_ovr)
    );

    assign mul_next = {add_co, sum, lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) begin
                if (is_rsv)            state_nx = S_DONE;
                else if (op == 2'b10)  state_nx = S_MUL;
                else                   state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_DONE;
            S_MUL:  if (cnt == 3'd7) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_r  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovr    <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    sub_r <= op[0];
                    a_r   <= a;
                    b_r   <= b;
                    hi    <= '0;
                    lo    <= b;
                    cnt   <= '0;
                    if (is_rsv) begin
                        result <= '0;
                        cout   <= 1'b0;
                        ovr    <= 1'b0;
                        zero   <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    result <= {{WIDTH{1'b0}}, sum};
                    cout   <= add_co;
                    ovr    <= add_ovr;
                    zero   <= (sum == '0);
                    err    <= 1'b0;
                end
                S_MUL: begin
                    {hi, lo} <= mul_next;
                    cnt      <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        result <= mul_next;
                        cout   <= 1'b0;
                        ovr    <= (mul_next[2*WIDTH-1:WIDTH] != '0);
                        zero   <= (mul_next == '0);
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - directed self-checking bench for calc_seq

module tb_calc_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        cout, ovr, zero, err, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic seen_valid;

    calc_seq #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovr       (ovr),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one command and return the number of cycles from accept to out_valid (0 = timeout).
    task automatic run(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int l);
        @(negedge clk);
        check("in_ready_before_cmd", in_ready, 1'b1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_drops", out_valid, 1'b0);
        check("idle_after_take", busy, 1'b0);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // SUB 80-01: signed overflow, no borrow
        run(2'b01, 8'h80, 8'h01, lat);
        check("sub1_lat", lat, 2);
        check("sub1_result", result, 16'h007F);
        check("sub1_cout", cout, 1'b1);
        check("sub1_ovr", ovr, 1'b1);
        check("sub1_zero", zero, 1'b0);
        take();

        // SUB 05-07: borrow
        run(2'b01, 8'h05, 8'h07, lat);
        check("sub2_lat", lat, 2);
        check("sub2_result", result, 16'h00FE);
        check("sub2_cout", cout, 1'b0);
        check("sub2_ovr", ovr, 1'b0);
        take();

        // ADD FF+01: wraps to zero with carry
        run(2'b00, 8'hFF, 8'h01, lat);
        check("add_lat", lat, 2);
        check("add_result", result, 16'h0000);
        check("add_cout", cout, 1'b1);
        check("add_ovr", ovr, 1'b0);
        check("add_zero", zero, 1'b1);
        take();

        // MUL FF*FF with consumer stalled for 5 cycles
        run(2'b10, 8'hFF, 8'hFF, lat);
        check("mul_lat", lat, 9);
        for (int k = 0; k < 5; k++) begin
            check("mul_result_held", result, 16'hFE01);
            check("mul_valid_held", out_valid, 1'b1);
            check("mul_in_ready_done", in_ready, 1'b0);
            @(negedge clk);
        end
        check("mul_result", result, 16'hFE01);
        check("mul_ovr", ovr, 1'b1);
        check("mul_cout", cout, 1'b0);
        check("mul_zero", zero, 1'b0);
        take();

        // Reset after 4 MUL passes aborts the command
        @(negedge clk);
        op = 2'b10; a = 8'h03; b = 8'h05; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 seen_valid = seen_valid | out_valid;
        end
        @(negedge clk);
        check("mid_mul_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_result", result, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            seen_valid = seen_valid | out_valid;
            @(negedge clk);
        end
        check("abort_no_out_valid", seen_valid, 1'b0);

        // Reserved op, with a command pulsed while busy
        run(2'b11, 8'h12, 8'h34, lat);
        check("rsv_lat", lat, 1);
        check("rsv_err", err, 1'b1);
        check("rsv_result", result, 16'h0000);
        check("rsv_zero", zero, 1'b0);
        check("rsv_in_ready_busy", in_ready, 1'b0);
        op = 2'b00; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("rsv_still_done", out_valid, 1'b1);
        check("rsv_in_ready_busy2", in_ready, 1'b0);
        take();
        seen_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            seen_valid = seen_valid | busy | out_valid;
            @(negedge clk);
        end
        check("busy_cmd_dropped", seen_valid, 1'b0);

        // Clean ADD after error clears err
        run(2'b00, 8'h10, 8'h22, lat);
        check("add2_lat", lat, 2);
        check("add2_result", result, 16'h0032);
        check("add2_err", err, 1'b0);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
